// File: rtl/regfile_readout.sv
// regfile_readout
//   Read-side sequencer for the register bank. A Start in IDLE latches an
//   inclusive index range FirstReg..LastReg (wrapping NUM_REGS-1 -> 0). For
//   each index it drives RdAddr, captures the bank word one cycle later, and
//   offers it on a valid/ready stream. After the last word is taken it pulses
//   Done for one cycle. The bank is never written.
//
//   Stream handshake: OutValid/OutData/OutIndex are registered. Once OutValid
//   rises, all three hold steady until a rising edge sees OutValid && OutReady.
//   That edge completes the transfer. OutReady has no effect while OutValid=0.
//
// Ports
//   Clk       clock, rising edge
//   Clr       synchronous active-high reset, priority over everything
//   Start     begin a readout (only looked at in IDLE)
//   FirstReg  first index of the range, latched with Start
//   LastReg   last index of the range (inclusive), latched with Start
//   RdAddr    bank read address
//   RdData    bank read data, combinational from RdAddr
//   OutValid  stream valid
//   OutReady  stream ready
//   OutData   captured word
//   OutIndex  index of OutData
//   Busy      high while in FETCH/SEND/DONE
//   Done      one-cycle pulse after the last word is accepted
//   DbgState  current FSM state (IDLE=0, FETCH=1, SEND=2, DONE=3)
module regfile_readout #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Start,
  input  logic [ADDR_W-1:0] FirstReg,
  input  logic [ADDR_W-1:0] LastReg,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [DATA_W-1:0] RdData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [ADDR_W-1:0] OutIndex,
  output logic              Busy,
  output logic              Done,
  output logic [1:0]        DbgState
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] TOP_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [ADDR_W-1:0] last_idx, last_idx_n;
  logic [ADDR_W-1:0] rd_addr_n;
  logic              valid_n;
  logic [DATA_W-1:0] data_n;
  logic [ADDR_W-1:0] index_n;
  logic              busy_n;
  logic              done_n;
  logic [ADDR_W-1:0] ptr_inc;

  // Explicit wrap so NUM_REGS need not be a power of two.
  assign ptr_inc  = (ptr == TOP_IDX) ? '0 : ptr + 1'b1;
  assign DbgState = state;

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    last_idx_n = last_idx;
    rd_addr_n  = RdAddr;
    valid_n    = OutValid;
    data_n     = OutData;
    index_n    = OutIndex;
    busy_n     = Busy;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          ptr_n      = FirstReg;
          last_idx_n = LastReg;
          rd_addr_n  = FirstReg;
          busy_n     = 1'b1;
          state_n    = FETCH;
        end
      end
      FETCH: begin
        // RdAddr has been stable for this whole cycle, so RdData is the
        // word for ptr. Later bank writes cannot disturb the captured copy.
        data_n  = RdData;
        index_n = ptr;
        valid_n = 1'b1;
        state_n = SEND;
      end
      SEND: begin
        if (OutValid && OutReady) begin
          valid_n = 1'b0;
          if (ptr == last_idx) begin
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            ptr_n     = ptr_inc;
            rd_addr_n = ptr_inc;
            state_n   = FETCH;
          end
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state    <= IDLE;
      ptr      <= '0;
      last_idx <= '0;
      RdAddr   <= '0;
      OutValid <= 1'b0;
      OutData  <= '0;
      OutIndex <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      last_idx <= last_idx_n;
      RdAddr   <= rd_addr_n;
      OutValid <= valid_n;
      OutData  <= data_n;
      OutIndex <= index_n;
      Busy     <= busy_n;
      Done     <= done_n;
    end
  end

endmodule
